// File: rtl/bt_uart_pkg.sv
// Shared types and helpers for the Bluetooth UART transmit path.
// Pure declarations: no logic, no latency, no flow control.
package bt_uart_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int BT_DATA_W = 8;

    // Index of the highest set bit; callers pass a one-hot (or zero) vector.
    function automatic int unsigned onehot2idx(input logic [7:0] oh);
        onehot2idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) onehot2idx = unsigned'(i);
        end
    endfunction

endpackage

// File: rtl/bt_uart_rr_pick.sv
// Combinational round-robin picker: first set req bit after 'last', wrapping.
// Zero latency; no flow control of its own.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    always_comb begin
        int            cand;
        logic [IDX_W-1:0] ci;
        cand  = 0;
        ci    = '0;
        valid = 1'b0;
        idx   = '0;
        // Walk from farthest to nearest so the nearest hit is the one that sticks.
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = (int'(last) + k) % NUM_REQ;
            ci   = IDX_W'(cand);
            if (req[ci]) begin
                valid = 1'b1;
                idx   = ci;
            end
        end
    end

endmodule

// File: rtl/bt_uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding the BT UART TX core; 1-cycle grant bubble, then
// combinational passthrough with tx_ready steering the owner's ready. Stall release via BT_ARB_TIMEOUT_EN.
module bt_uart_tx_arbiter
    import bt_uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = BT_DATA_W,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        tx_valid,
    output logic [DATA_W-1:0]           tx_data,
    input  logic                        tx_ready,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        busy,
    output logic                        timeout
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_LOCK = LOCK;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("bt_uart_tx_arbiter: parameter out of range");
    end

    logic [0:0]         state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   g;
    logic               lock;
    logic               hs;
    logic               last_hs;
    logic               force_rel;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .last  (last_q),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    always_comb begin
        lock      = (state_q == ST_LOCK);
        g         = IDX_W'(onehot2idx(8'(grant_q)));
        tx_valid  = lock & req_valid[g];
        tx_data   = req_data[g*DATA_W +: DATA_W];
        req_ready = lock ? (grant_q & {NUM_REQ{tx_ready}}) : '0;
        hs        = tx_valid & tx_ready;
        last_hs   = hs & req_last[g];
    end

`ifdef BT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] stall_cnt_q;
    logic             timeout_q;

    assign force_rel = lock & ~hs & (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout   = timeout_q;

    // Counter sits at zero while idle, so it is already clear on entry to LOCK.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= force_rel;
            if (!lock || hs || force_rel) stall_cnt_q <= '0;
            else                          stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        state_q <= ST_LOCK;
                        grant_q <= NUM_REQ'(1) << pick_idx;
                    end
                end
                default: begin
                    if (last_hs || force_rel) begin
                        state_q <= ST_IDLE;
                        grant_q <= '0;
                        last_q  <= g;
                    end
                end
            endcase
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == ST_LOCK);

endmodule

// File: tb/tb_bt_uart_tx_arbiter.sv
// Directed, table-driven bench for bt_uart_tx_arbiter (4 requesters, 8-bit bytes, 16-cycle stall limit).
module tb_bt_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bt_uart_tx_arbiter #(
        .NUM_REQ        (4),
        .DATA_W         (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .grant     (grant),
        .busy      (busy),
        .timeout   (timeout)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  vld;
        logic [3:0]  last;
        logic [31:0] dat;
        logic        rdy;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_txv;
        logic [7:0]  e_txd;
        logic [3:0]  e_rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] last,
                       input logic [31:0] dat, input logic rdy, input logic [3:0] eg,
                       input logic eb, input logic etv, input logic [7:0] etd, input logic [3:0] er);
        vec_t v;
        v.rst = rst; v.vld = vld; v.last = last; v.dat = dat; v.rdy = rdy;
        v.e_grant = eg; v.e_busy = eb; v.e_txv = etv; v.e_txd = etd; v.e_rdy = er;
        vecs.push_back(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] vld, input logic [3:0] last,
                         input logic [31:0] dat, input logic rdy);
        req_valid = vld;
        req_last  = last;
        req_data  = dat;
        tx_ready  = rdy;
    endtask

    initial begin
        int          idx;
        int          outcnt;
        int          n_lock;
        bit          done;
        bit          have_stall;
        logic [7:0]  stall_dat;
        logic [3:0]  pat;
        logic [7:0]  b;

        // Packet from req0 only
        add(0, 4'b0001, 4'b0000, 32'h0000_00A1, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0000_00A1, 1, 4'b0001, 1, 1, 8'hA1, 4'b0001);
        add(0, 4'b0001, 4'b0000, 32'h0000_00A2, 1, 4'b0001, 1, 1, 8'hA2, 4'b0001);
        add(0, 4'b0001, 4'b0001, 32'h0000_00A3, 1, 4'b0001, 1, 1, 8'hA3, 4'b0001);
        add(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        // Reset to restart rotation at req0, then all four send 1-byte packets
        add(1, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0001, 1, 1, 8'hC0, 4'b0001);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0010, 1, 1, 8'hC1, 4'b0010);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0100, 1, 1, 8'hC2, 4'b0100);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b1000, 1, 1, 8'hC3, 4'b1000);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b1111, 4'b1111, 32'hC3C2_C1C0, 1, 4'b0001, 1, 1, 8'hC0, 4'b0001);
        add(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        // req0 4-byte packet, req2 asks after the first byte and must wait
        add(0, 4'b0001, 4'b0000, 32'h0000_00B0, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b0001, 4'b0000, 32'h0000_00B0, 1, 4'b0001, 1, 1, 8'hB0, 4'b0001);
        add(0, 4'b0101, 4'b0100, 32'h00E2_00B1, 1, 4'b0001, 1, 1, 8'hB1, 4'b0001);
        add(0, 4'b0101, 4'b0100, 32'h00E2_00B2, 1, 4'b0001, 1, 1, 8'hB2, 4'b0001);
        add(0, 4'b0101, 4'b0101, 32'h00E2_00B3, 1, 4'b0001, 1, 1, 8'hB3, 4'b0001);
        add(0, 4'b0100, 4'b0100, 32'h00E2_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);
        add(0, 4'b0100, 4'b0100, 32'h00E2_0000, 1, 4'b0100, 1, 1, 8'hE2, 4'b0100);
        add(0, 4'b0000, 4'b0000, 32'h0000_0000, 1, 4'b0000, 0, 0, 8'h00, 4'b0000);

        reset = 1'b1;
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        next_cycle();
        next_cycle();
        #3;
        chk("rst_grant",   32'(grant),     32'h0);
        chk("rst_busy",    32'(busy),      32'h0);
        chk("rst_txv",     32'(tx_valid),  32'h0);
        chk("rst_ready",   32'(req_ready), 32'h0);
        chk("rst_timeout", 32'(timeout),   32'h0);
        next_cycle();

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            drive(vecs[i].vld, vecs[i].last, vecs[i].dat, vecs[i].rdy);
            #3;
            chk($sformatf("v%0d_grant", i), 32'(grant),     32'(vecs[i].e_grant));
            chk($sformatf("v%0d_busy", i),  32'(busy),      32'(vecs[i].e_busy));
            chk($sformatf("v%0d_txv", i),   32'(tx_valid),  32'(vecs[i].e_txv));
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_rdy));
            if (vecs[i].e_txv) chk($sformatf("v%0d_txd", i), 32'(tx_data), 32'(vecs[i].e_txd));
            next_cycle();
        end
        reset = 1'b0;

        // tx_ready stalls 1,0,0,1 during a 5-byte packet from req1
        idx = 0; outcnt = 0; done = 0; have_stall = 0; stall_dat = '0; pat = 4'b1001;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            b = 8'h50 + 8'(idx);
            drive((idx < 5) ? 4'b0010 : 4'b0000, (idx == 4) ? 4'b0010 : 4'b0000,
                  {16'h0, b, 8'h0}, pat[cyc % 4]);
            #3;
            if (have_stall) chk("t4_stall_hold", 32'(tx_data), 32'(stall_dat));
            have_stall = 0;
            if (tx_valid && tx_ready) begin
                chk("t4_byte", 32'(tx_data), 32'(8'h50 + 8'(outcnt)));
                outcnt++;
                if (req_last[1]) done = 1;
            end else if (tx_valid) begin
                have_stall = 1;
                stall_dat  = tx_data;
            end
            if (req_valid[1] && req_ready[1]) idx++;
            next_cycle();
        end
        chk("t4_out_count", 32'(outcnt), 32'd5);
        chk("t4_in_count",  32'(idx),    32'd5);
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        #3;
        chk("t4_released", 32'(grant), 32'h0);
        next_cycle();

        // Reset after 2 of 4 bytes from req0
        drive(4'b0001, 4'b0000, 32'h0000_0090, 1'b1);
        next_cycle();
        next_cycle();
        drive(4'b0001, 4'b0000, 32'h0000_0091, 1'b1);
        #3;
        chk("t5_lock_before_rst", 32'(grant), 32'h1);
        next_cycle();
        reset = 1'b1;
        drive(4'b0001, 4'b0000, 32'h0000_0092, 1'b0);
        next_cycle();
        reset = 1'b0;
        drive(4'b0011, 4'b0000, 32'h0000_8192, 1'b0);
        #3;
        chk("t5_grant_after_rst", 32'(grant),    32'h0);
        chk("t5_txv_after_rst",   32'(tx_valid), 32'h0);
        next_cycle();
        #3;
        chk("t5_regrant_req0", 32'(grant), 32'h1);
        next_cycle();
        drive(4'b0001, 4'b0001, 32'h0000_0093, 1'b1);
        next_cycle();
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        #3;
        chk("t5_done", 32'(grant), 32'h0);
        next_cycle();

        // Owner req3 sends one byte then goes silent while req2 waits
        drive(4'b1000, 4'b0000, 32'h7700_0000, 1'b1);
        next_cycle();
        #3;
        chk("t6_grant3", 32'(grant), 32'h8);
        next_cycle();
        drive(4'b0100, 4'b0100, 32'h0066_0000, 1'b1);
`ifdef BT_ARB_TIMEOUT_EN
        n_lock = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #3;
            if (grant != 4'b1000) break;
            n_lock++;
            next_cycle();
        end
        chk("t6_stall_cycles", 32'(n_lock),  32'd16);
        chk("t6_timeout_hi",   32'(timeout), 32'h1);
        chk("t6_grant_zero",   32'(grant),   32'h0);
        next_cycle();
        #3;
        chk("t6_timeout_lo", 32'(timeout), 32'h0);
        chk("t6_next_grant", 32'(grant),   32'h4);
        next_cycle();
`else
        n_lock = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            #3;
            if (grant == 4'b1000 && busy && !timeout && !tx_valid) n_lock++;
            next_cycle();
        end
        chk("t6_held_1000", 32'(n_lock), 32'd1000);
        drive(4'b1100, 4'b1100, 32'h7866_0000, 1'b1);
        #3;
        chk("t6_final_byte", 32'(tx_data), 32'h78);
        next_cycle();
        #3;
        chk("t6_release", 32'(grant), 32'h0);
        next_cycle();
        #3;
        chk("t6_next_grant", 32'(grant), 32'h4);
        next_cycle();
`endif
        drive(4'b0000, 4'b0000, 32'h0, 1'b1);
        next_cycle();
        #3;
        chk("t6_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
